// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run/debug controller: run_state encodings and
// the breakpoint index width.
package cpu_dbg_pkg;

  // run_state encodings as seen on the run_state port
  localparam logic [1:0] RsResetHold = 2'd0;
  localparam logic [1:0] RsHalted    = 2'd1;
  localparam logic [1:0] RsRunning   = 2'd2;
  localparam logic [1:0] RsStepping  = 2'd3;

  // Width of bp_idx; covers up to 8 breakpoints
  localparam int unsigned BpIdxW = 3;

  typedef enum logic [1:0] {
    StResetHold = RsResetHold,
    StHalted    = RsHalted,
    StRunning   = RsRunning,
    StStepping  = RsStepping
  } run_state_e;

endpackage

// File: rtl/cpu_bp_match.sv
// Breakpoint comparator bank: flags a PC match on any enabled breakpoint and
// reports the lowest matching index.
module cpu_bp_match
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned NUM_BP     = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [NUM_BP-1:0]            bp_en,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
  input  logic [ADDR_WIDTH-1:0]        pc,
  output logic                         match,
  output logic [BpIdxW-1:0]            idx
);

  // Ascending scan; the first hit is kept so the lowest index wins
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (!match && bp_en[i] && (bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == pc)) begin
        match = 1'b1;
        idx   = BpIdxW'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/reset controller for the MultiCycleCPU: sequences the core reset, gates
// the core clock enable, and provides halt, single-step, PC breakpoints and
// saturating cycle/instruction counters.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 2,
  parameter int unsigned START_RUNNING   = 1,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned NUM_BP          = 2,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run_req,
  input  logic                         halt_req,
  input  logic                         step_req,
  input  logic [NUM_BP-1:0]            bp_en,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
  input  logic [ADDR_WIDTH-1:0]        cpu_pc,
  input  logic                         cpu_instr_done,
  output logic                         cpu_reset,
  output logic                         cpu_clk_en,
  output logic [1:0]                   run_state,
  output logic                         bp_hit,
  output logic [BpIdxW-1:0]            bp_idx,
  output logic [CNT_WIDTH-1:0]         cycle_count,
  output logic [CNT_WIDTH-1:0]         instr_count
);

  localparam int unsigned HoldW = (RST_HOLD_CYCLES < 2) ? 1 : $clog2(RST_HOLD_CYCLES + 1);

  run_state_e           state_q;
  logic [HoldW-1:0]     hold_q;
  logic                 pending_q;
  logic                 cpu_reset_q;
  logic                 bp_hit_q;
  logic [BpIdxW-1:0]    bp_idx_q;
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instr_q;

  logic                 bp_match;
  logic [BpIdxW-1:0]    bp_match_idx;
  logic                 halt_pend;

  cpu_bp_match #(
    .NUM_BP     (NUM_BP),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bp_match (
    .bp_en (bp_en),
    .bp_addr (bp_addr),
    .pc    (cpu_pc),
    .match (bp_match),
    .idx   (bp_match_idx)
  );

  // Clock enable decoded from the state register only; a halt request seen in
  // the boundary cycle still counts for that boundary
  always_comb begin
    cpu_clk_en = (state_q == StRunning) || (state_q == StStepping);
    halt_pend  = pending_q | halt_req;
  end

  // Run FSM, reset hold counter, pending halt, breakpoint status and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StResetHold;
      hold_q      <= HoldW'(RST_HOLD_CYCLES);
      pending_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      bp_hit_q    <= 1'b0;
      bp_idx_q    <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
    end else begin
      if (cpu_clk_en && (cycle_q != '1)) begin
        cycle_q <= cycle_q + CNT_WIDTH'(1);
      end
      if (cpu_clk_en && cpu_instr_done && (instr_q != '1)) begin
        instr_q <= instr_q + CNT_WIDTH'(1);
      end

      unique case (state_q)
        StResetHold: begin
          // Requests are ignored until the hold expires
          if (hold_q <= HoldW'(1)) begin
            hold_q      <= '0;
            cpu_reset_q <= 1'b0;
            state_q     <= (START_RUNNING != 0) ? StRunning : StHalted;
          end else begin
            hold_q <= hold_q - HoldW'(1);
          end
        end
        StHalted: begin
          pending_q <= 1'b0;
          if (run_req) begin
            state_q  <= StRunning;
            bp_hit_q <= 1'b0;
          end else if (step_req) begin
            state_q  <= StStepping;
            bp_hit_q <= 1'b0;
          end
        end
        StRunning: begin
          if (cpu_instr_done && (halt_pend || bp_match)) begin
            state_q   <= StHalted;
            pending_q <= 1'b0;
            if (bp_match) begin
              bp_hit_q <= 1'b1;
              bp_idx_q <= bp_match_idx;
            end
          end else begin
            pending_q <= halt_pend;
          end
        end
        StStepping: begin
          // A step always stops at its boundary; breakpoints are not checked
          if (cpu_instr_done) begin
            state_q   <= StHalted;
            pending_q <= 1'b0;
          end else begin
            pending_q <= halt_pend;
          end
        end
        default: state_q <= StResetHold;
      endcase
    end
  end

  // Registered outputs
  always_comb begin
    cpu_reset   = cpu_reset_q;
    run_state   = state_q;
    bp_hit      = bp_hit_q;
    bp_idx      = bp_idx_q;
    cycle_count = cycle_q;
    instr_count = instr_q;
  end

endmodule
